uart_boot_loader: RTL



---
 rtl/boot_pkg.sv | 25 ++
 rtl/boot_word_assembler.sv | 68 ++++++
 rtl/uart_boot_loader.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared types and helpers for the UART boot loader.
//   boot_state_t : load FSM states
//   BOOT_CKSUM_W : width of the trailing frame checksum
//   lane_idx()   : maps the n-th received byte to its byte lane for the configured endianness
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        CHECK,
        DONE,
        ERROR
    } boot_state_t;

    localparam int unsigned BOOT_CKSUM_W = 8;

    // Little endian: byte n lands in lane n. Big endian: byte n lands in lane n_lanes-1-n.
    function automatic int unsigned lane_idx(input int unsigned idx,
                                             input int unsigned n_lanes,
                                             input bit          big_endian);
        return big_endian ? (n_lanes - 1 - idx) : idx;
    endfunction

endpackage

// File: rtl/boot_word_assembler.sv
// Packs a byte stream into WORD_BYTES-wide words.
//   clk, rst          : clock, synchronous active-high reset
//   clear             : restart at byte lane 0 (new frame)
//   byte_valid        : accept byte_data this cycle
//   byte_data         : incoming byte
//   word_done_c       : combinational, this byte completes a word
//   word_valid, word  : registered one-cycle strobe and completed word
module boot_word_assembler
    import boot_pkg::*;
#(
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned BIG_ENDIAN = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    byte_valid,
    input  logic [7:0]              byte_data,
    output logic                    word_done_c,
    output logic                    word_valid,
    output logic [8*WORD_BYTES-1:0] word
);

    localparam int unsigned WORD_W = 8 * WORD_BYTES;
    localparam int unsigned IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] fill;
    logic [WORD_W-1:0] fill_c;
    int unsigned       lane_c;

    // Current partial word with the incoming byte merged into its lane
    always_comb begin
        lane_c = lane_idx(32'(idx), WORD_BYTES, BIG_ENDIAN != 0);
        fill_c = fill;
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            if (i == lane_c) begin
                fill_c[8*i +: 8] = byte_data;
            end
        end
    end

    assign word_done_c = byte_valid && (idx == IDX_W'(WORD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            fill       <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                idx <= '0;
            end else if (byte_valid) begin
                fill <= fill_c;
                if (word_done_c) begin
                    idx        <= '0;
                    word_valid <= 1'b1;
                    word       <= fill_c;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// UART program-image loader for instruction memory.
// Frame: LEN_BYTES word-count header, N*WORD_BYTES payload bytes, and with
// BOOT_CHECKSUM_EN defined one trailing modulo-256 sum of the payload bytes.
//   clk, rst             : clock, synchronous active-high reset
//   flash                : level request to load; dropping it mid-load aborts
//   byte_valid/byte_data : received UART byte strobe and data
//   imem_we/addr/wdata   : instruction-memory word write port
//   core_hold, core_rst  : pipeline freeze and one-cycle restart pulse
//   busy, done, error    : load status (done is a pulse, error is sticky)
//   word_count           : words written in the current or last load
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned WORD_BYTES     = 4,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned LEN_BYTES      = 2,
    parameter int unsigned BIG_ENDIAN     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flash,
    input  logic                    byte_valid,
    input  logic [7:0]              byte_data,
    output logic                    imem_we,
    output logic [ADDR_WIDTH-1:0]   imem_addr,
    output logic [8*WORD_BYTES-1:0] imem_wdata,
    output logic                    core_hold,
    output logic                    core_rst,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [ADDR_WIDTH:0]     word_count
);

    localparam int unsigned LEN_W  = 8 * LEN_BYTES;
    localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
    localparam int unsigned HIDX_W = (LEN_BYTES > 1) ? $clog2(LEN_BYTES) : 1;
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

`ifdef BOOT_CHECKSUM_EN
    localparam boot_state_t POST_PAYLOAD = CHECK;
`else
    localparam boot_state_t POST_PAYLOAD = DONE;
`endif

    boot_state_t       state, state_next;
    logic [HIDX_W-1:0] hdr_idx;
    logic [LEN_W-1:0]  len_q, len_c;
    logic [CNT_W-1:0]  n_q;
    logic [CNT_W-1:0]  asm_cnt;
    logic [TO_W-1:0]   idle_cnt;
    logic              enter_hdr_c, hdr_acc_c, pay_acc_c, any_acc_c;
    logic              hdr_last_c, len_big_c, len_zero_c;
    logic              tick_c, timeout_c, word_done_c;

    assign enter_hdr_c = (state == IDLE) && flash;
    assign hdr_acc_c   = byte_valid && flash && (state == HEADER);
    // Stop feeding the assembler once all N words have been collected
    assign pay_acc_c   = byte_valid && flash && (state == PAYLOAD) && (asm_cnt < n_q);
    assign hdr_last_c  = hdr_idx == HIDX_W'(LEN_BYTES - 1);

    // Header value including the byte arriving this cycle
    always_comb begin
        len_c = len_q;
        for (int unsigned i = 0; i < LEN_BYTES; i++) begin
            if (i == lane_idx(32'(hdr_idx), LEN_BYTES, BIG_ENDIAN != 0)) begin
                len_c[8*i +: 8] = byte_data;
            end
        end
    end

    assign len_big_c  = 64'(len_c) > (64'd1 << ADDR_WIDTH);
    assign len_zero_c = len_c == '0;

`ifdef BOOT_CHECKSUM_EN
    logic [BOOT_CKSUM_W-1:0] cksum;
    logic                    chk_acc_c;

    assign chk_acc_c = byte_valid && flash && (state == CHECK);
    assign any_acc_c = hdr_acc_c || pay_acc_c || chk_acc_c;

    // Running payload sum, header bytes excluded
    always_ff @(posedge clk) begin
        if (rst || enter_hdr_c) begin
            cksum <= '0;
        end else if (pay_acc_c) begin
            cksum <= cksum + byte_data;
        end
    end
`else
    assign any_acc_c = hdr_acc_c || pay_acc_c;
`endif

    // Inter-byte timeout runs once a frame has started
    assign tick_c    = ((state == HEADER) && (hdr_idx != '0)) || (state == PAYLOAD)
                       || (state == CHECK);
    assign timeout_c = tick_c && !any_acc_c && (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    boot_word_assembler #(
        .WORD_BYTES (WORD_BYTES),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_asm (
        .clk         (clk),
        .rst         (rst),
        .clear       (enter_hdr_c),
        .byte_valid  (pay_acc_c),
        .byte_data   (byte_data),
        .word_done_c (word_done_c),
        .word_valid  (imem_we),
        .word        (imem_wdata)
    );

    assign imem_addr = word_count[ADDR_WIDTH-1:0];

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (flash) state_next = HEADER;
            end
            HEADER: begin
                if (!flash || timeout_c) begin
                    state_next = ERROR;
                end else if (hdr_acc_c && hdr_last_c) begin
                    if (len_big_c)       state_next = ERROR;
                    else if (len_zero_c) state_next = POST_PAYLOAD;
                    else                 state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!flash || timeout_c) begin
                    state_next = ERROR;
`ifdef BOOT_CHECKSUM_EN
                // Move on as soon as the last word is assembled; its write
                // still completes while the checksum byte is awaited.
                end else if (word_done_c && (asm_cnt + CNT_W'(1) == n_q)) begin
                    state_next = CHECK;
`else
                end else if (imem_we && (word_count + CNT_W'(1) == n_q)) begin
                    state_next = DONE;
`endif
                end
            end
`ifdef BOOT_CHECKSUM_EN
            CHECK: begin
                if (!flash || timeout_c) begin
                    state_next = ERROR;
                end else if (chk_acc_c) begin
                    state_next = (byte_data == cksum) ? DONE : ERROR;
                end
            end
`endif
            DONE: begin
                if (!flash) state_next = IDLE;
            end
            ERROR: begin
                if (!flash) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counters and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hdr_idx    <= '0;
            len_q      <= '0;
            n_q        <= '0;
            asm_cnt    <= '0;
            word_count <= '0;
            idle_cnt   <= '0;
            core_hold  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            core_rst   <= 1'b0;
            error      <= 1'b0;
        end else begin
            state     <= state_next;
            core_hold <= state_next != IDLE;
            busy      <= (state_next == HEADER) || (state_next == PAYLOAD)
                         || (state_next == CHECK);
            done      <= (state_next == DONE) && (state != DONE);
            core_rst  <= (state_next == DONE) && (state != DONE);

            if (enter_hdr_c)                error <= 1'b0;
            else if (state_next == ERROR)   error <= 1'b1;

            if (enter_hdr_c) begin
                hdr_idx    <= '0;
                len_q      <= '0;
                n_q        <= '0;
                asm_cnt    <= '0;
                word_count <= '0;
                idle_cnt   <= '0;
            end else begin
                if (hdr_acc_c) begin
                    len_q   <= len_c;
                    hdr_idx <= hdr_idx + HIDX_W'(1);
                    if (hdr_last_c) n_q <= CNT_W'(len_c);
                end
                if (word_done_c) asm_cnt <= asm_cnt + CNT_W'(1);
                if (imem_we)     word_count <= word_count + CNT_W'(1);
                if (any_acc_c || !tick_c) idle_cnt <= '0;
                else                      idle_cnt <= idle_cnt + TO_W'(1);
            end
        end
    end

endmodule
